tmr_count_clock_ctrl: RTL
=========================

// Module: tmr_count_clock_ctrl
// PURPOSE
//  Count-clock controller for the two 8-bit timer channels.
//  - Owns the shared free-running prescaler; decodes per-channel clock select.
//  - Synchronises and edge-detects the TMCI0/TMCI1 pins.
//  - Routes the cascade sources: ch1 overflow -> ch0, ch0 compare-match A -> ch1.
//  - Issues one registered single-cycle count-enable per channel; the TCNT logic counts on it.
// PARAMETERS
//  PRESCALE_W   13  prescaler width (covers P/8192); must be >= 13
//  SYNC_STAGES  2   flip-flop stages on each TMCI pin synchroniser; >= 2
// PORTS
//  clk        in   1   peripheral clock P; sole clock
//  rst        in   1   synchronous, active-high reset
//  cks0       in   3   ch0 clock select (encoding below)
//  cks1       in   3   ch1 clock select
//  ext0       in   2   ch0 ext mode when cks0==111: 00 rise, 01 fall, 10 both, 11 cascade
//  ext1       in   2   ch1 ext mode when cks1==111 (same encoding)
//  tmci0      in   1   external clock pin ch0, asynchronous
//  tmci1      in   1   external clock pin ch1, asynchronous
//  ovf1       in   1   ch1 overflow pulse (ch0 cascade source)
//  cmfa0      in   1   ch0 compare-match A pulse (ch1 cascade source)
//  count_en0  out  1   ch0 count-enable pulse
//  count_en1  out  1   ch1 count-enable pulse
//  prescaler  out  PRESCALE_W  prescaler value
//  cascade_err out 1   both channels select cascade (illegal loop)
// BEHAVIOUR
//  Reset outputs:
//  - All outputs 0 and prescaler=0.
//  - Synchroniser, edge-history and cks_q registers are cleared.
//  Prescaler: +1 every cycle, wraps at 2^PRESCALE_W, never stops.
//  Tick for a divide of 2^k is true when prescaler[k-1:0] is all ones.
//  Clock select (cks):
//  - 000 stop
//  - 001 P/2 (k=1); 010 P/8 (k=3); 011 P/32 (k=5)
//  - 100 P/64 (k=6); 101 P/1024 (k=10); 110 P/8192 (k=13)
//  - 111 external or cascade, as set by ext
//  Outputs are registered: the source event in cycle n gives count_en high in cycle n+1, for exactly 1 cycle.
//  Prescaled timing:
//  - A pulse is high in each cycle where prescaler[k-1:0] has just wrapped to 0.
//  - Cycle 0 is the first cycle after rst deasserts. First P/2 pulse is in cycle 2; first P/8192 pulse is in cycle 8192.
//  External timing:
//  - Each pin passes through SYNC_STAGES FFs, then a history FF.
//  - Edge = synchronised value != history, filtered by mode.
//  - A pin transition sampled at clock n gives count_en in cycle n+SYNC_STAGES+1 (=3 by default).
//  - Only levels held >=2 clk cycles are guaranteed to be counted; shorter pulses may be dropped.
//  Cascade:
//  - count_en0 = ovf1 delayed 1 cycle.
//  - count_en1 = cmfa0 delayed 1 cycle.
//  - Both channels in cascade: cascade_err=1 (registered, 1 cycle latency); both count_en forced 0 until the config changes.
//  Select change:
//  - cks_q/ext_q hold the registered selection.
//  - In a cycle where {cks,ext} != {cks_q,ext_q}, that channel's event is suppressed and cks_q/ext_q update.
//  - In the same cycle, the history FF loads the current synchronised value, so a pin already high gives no false edge.
//  - Normal operation resumes the next cycle, aligned to the shared prescaler; the prescaler is never reset.
//  Simultaneous events: at most one pulse per channel per cycle; the channels are fully independent.
//  Reset mid-operation: outputs drop to 0 in the next cycle. An in-flight pulse or synchroniser edge is discarded, not replayed.
// TESTING
//  1. rst=1 for 3 cycles, all cks=111 ext=00 tmci=1 -> all outputs 0; prescaler=0 in cycle 0; no pulse afterwards (history cleared, then loaded on the first select-change cycle).
//  2. cks0=001, cks1=110 from reset -> count_en0 high in cycles 2,4,6...; count_en1 first high in cycle 8192, then every 8192 cycles.
//  3. cks0=111 ext0=00, tmci0 square wave 4 high/4 low -> one pulse per rise, 3 cycles after the rise; ext0=10 -> 2 pulses per period.
//  4. cks0=111 ext0=11, ovf1 pulse at cycle 50 -> count_en0 in cycle 51; then set ch1 to cascade -> cascade_err=1 next cycle, no pulses on either channel.
//  5. Switch cks0 001->010 at cycle 101 -> no pulse in cycle 102; next pulse at the first wrap of prescaler[2:0]; P/2 pulses stop.
//  6. Assert rst for 1 cycle during a P/8 run at prescaler=37 -> outputs 0, prescaler 0, pulse cadence restarts from cycle 0 rules.

Source files
------------

// File: rtl/tmr_count_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tmr_count_clock_ctrl
// Purpose : Count-clock controller for two 8-bit timer channels. Owns the
//           shared free-running prescaler, decodes each channel's clock
//           select, synchronises and edge-detects the TMCI pins, routes the
//           cascade sources and issues one registered single-cycle
//           count-enable pulse per channel.
// Ports   : clk, rst            - peripheral clock, sync active-high reset
//           cks0_i / cks1_i     - per-channel clock select
//           ext0_i / ext1_i     - per-channel external/cascade mode
//           tmci0_i / tmci1_i   - asynchronous external clock pins
//           ovf1_i, cmfa0_i     - cascade sources (ch1 ovf -> ch0, ch0 CMA -> ch1)
//           count_en0_o/1_o     - count-enable pulses
//           prescaler_o         - current prescaler value
//           cascade_err_o       - both channels select cascade
// Revision: 1.0 - initial release
// ============================================================================
module tmr_count_clock_ctrl #(
  parameter int PRESCALE_W  = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cks0_i,
  input  logic [2:0]            cks1_i,
  input  logic [1:0]            ext0_i,
  input  logic [1:0]            ext1_i,
  input  logic                  tmci0_i,
  input  logic                  tmci1_i,
  input  logic                  ovf1_i,
  input  logic                  cmfa0_i,
  output logic                  count_en0_o,
  output logic                  count_en1_o,
  output logic [PRESCALE_W-1:0] prescaler_o,
  output logic                  cascade_err_o
);

  localparam logic [2:0] CKS_STOP    = 3'b000;
  localparam logic [2:0] CKS_DIV2    = 3'b001;
  localparam logic [2:0] CKS_DIV8    = 3'b010;
  localparam logic [2:0] CKS_DIV32   = 3'b011;
  localparam logic [2:0] CKS_DIV64   = 3'b100;
  localparam logic [2:0] CKS_DIV1024 = 3'b101;
  localparam logic [2:0] CKS_DIV8192 = 3'b110;
  localparam logic [2:0] CKS_EXT     = 3'b111;

  localparam logic [1:0] EXT_RISE = 2'b00;
  localparam logic [1:0] EXT_FALL = 2'b01;
  localparam logic [1:0] EXT_BOTH = 2'b10;
  localparam logic [1:0] EXT_CASC = 2'b11;

  // One extra stage beyond the synchroniser: the history FF must hold a
  // post-reset sample before an edge can be trusted.
  localparam int WARM_W = SYNC_STAGES + 1;

  localparam logic [PRESCALE_W-1:0] PS_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0]        prescaler_q;
  logic [1:0][2:0]              cks_q;
  logic [1:0][1:0]              ext_q;
  logic [1:0][SYNC_STAGES-1:0]  sync_q;
  logic [1:0]                   hist_q;
  logic [WARM_W-1:0]            warm_q;
  logic [1:0]                   count_en_q, count_en_d;
  logic                         cascade_err_q, cascade_err_d;

  logic [1:0][2:0] w_cks;
  logic [1:0][1:0] w_ext;
  logic [1:0]      w_pin;
  logic [1:0]      w_casc_src;
  logic [1:0]      w_casc_sel;
  logic [1:0]      w_sync;
  logic [5:0]      w_tick;
  logic            w_edge_ok;
  logic [1:0]      src_ev;
  logic [1:0]      sel_chg;

  assign w_cks      = {cks1_i, cks0_i};
  assign w_ext      = {ext1_i, ext0_i};
  assign w_pin      = {tmci1_i, tmci0_i};
  assign w_casc_src = {cmfa0_i, ovf1_i};
  assign w_casc_sel[0] = (cks0_i == CKS_EXT) && (ext0_i == EXT_CASC);
  assign w_casc_sel[1] = (cks1_i == CKS_EXT) && (ext1_i == EXT_CASC);
  assign w_sync[0]  = sync_q[0][SYNC_STAGES-1];
  assign w_sync[1]  = sync_q[1][SYNC_STAGES-1];
  assign w_edge_ok  = warm_q[WARM_W-1];

  // Divide-by-2^k tick: low k prescaler bits all ones.
  assign w_tick = {&prescaler_q[12:0], &prescaler_q[9:0], &prescaler_q[5:0],
                   &prescaler_q[4:0],  &prescaler_q[2:0], prescaler_q[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= '0;
      cks_q         <= '0;
      ext_q         <= '0;
      sync_q        <= '0;
      hist_q        <= '0;
      warm_q        <= '0;
      count_en_q    <= '0;
      cascade_err_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_q + PS_ONE;
      warm_q        <= {warm_q[WARM_W-2:0], 1'b1};
      // Selection registers simply track the inputs; a mismatch marks the
      // single cycle in which the channel's event is suppressed.
      cks_q         <= w_cks;
      ext_q         <= w_ext;
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], w_pin[ch]};
        // History always follows the synchronised level, including the
        // select-change cycle, so a pin already high never looks like an edge.
        hist_q[ch] <= w_sync[ch];
      end
      count_en_q    <= count_en_d;
      cascade_err_q <= cascade_err_d;
    end
  end

  always_comb begin
    cascade_err_d = w_casc_sel[0] & w_casc_sel[1];
    src_ev        = '0;
    sel_chg       = '0;
    count_en_d    = '0;
    for (int ch = 0; ch < 2; ch++) begin
      sel_chg[ch] = {w_cks[ch], w_ext[ch]} != {cks_q[ch], ext_q[ch]};
      unique case (cks_q[ch])
        CKS_STOP:    src_ev[ch] = 1'b0;
        CKS_DIV2:    src_ev[ch] = w_tick[0];
        CKS_DIV8:    src_ev[ch] = w_tick[1];
        CKS_DIV32:   src_ev[ch] = w_tick[2];
        CKS_DIV64:   src_ev[ch] = w_tick[3];
        CKS_DIV1024: src_ev[ch] = w_tick[4];
        CKS_DIV8192: src_ev[ch] = w_tick[5];
        CKS_EXT: begin
          unique case (ext_q[ch])
            EXT_RISE: src_ev[ch] = w_edge_ok &  w_sync[ch] & ~hist_q[ch];
            EXT_FALL: src_ev[ch] = w_edge_ok & ~w_sync[ch] &  hist_q[ch];
            EXT_BOTH: src_ev[ch] = w_edge_ok & (w_sync[ch] ^ hist_q[ch]);
            EXT_CASC: src_ev[ch] = w_casc_src[ch];
          endcase
        end
      endcase
      // The cascade loop check uses the live selection so both channels go
      // quiet in the same cycle the illegal configuration appears.
      count_en_d[ch] = src_ev[ch] & ~sel_chg[ch] & ~cascade_err_d;
    end
  end

  assign count_en0_o   = count_en_q[0];
  assign count_en1_o   = count_en_q[1];
  assign prescaler_o   = prescaler_q;
  assign cascade_err_o = cascade_err_q;

endmodule
`default_nettype wire
